// File: rtl/of_lookup_arbiter_pkg.sv
// Shared action-word definitions and arbiter-local types for the lookup result merge.
package of_lookup_arbiter_pkg;

  // Action word geometry shared with the lookup engines and the action processor.
  localparam int unsigned OF_ACTION_DATA_WIDTH = 64;
  localparam int unsigned OF_ACTION_CTRL_WIDTH = 16;

  // Action field positions.
  localparam int unsigned OF_ACTION_CTRL_OUTPUT_PORT_POS   = 0;
  localparam int unsigned OF_ACTION_DATA_OUTPUT_PORT_POS   = 0;
  localparam int unsigned OF_ACTION_DATA_OUTPUT_PORT_WIDTH = 16;

  // One-hot output-port mask of the CPU port.
  localparam logic [OF_ACTION_DATA_OUTPUT_PORT_WIDTH-1:0] OF_CPU_PORT_MASK =
    OF_ACTION_DATA_OUTPUT_PORT_WIDTH'(2);

  // Default miss action: forward the packet to the CPU port.
  localparam logic [OF_ACTION_CTRL_WIDTH-1:0] OF_MISS_ACTION_CTRL =
    OF_ACTION_CTRL_WIDTH'(1) << OF_ACTION_CTRL_OUTPUT_PORT_POS;
  localparam logic [OF_ACTION_DATA_WIDTH-1:0] OF_MISS_ACTION_DATA =
    OF_ACTION_DATA_WIDTH'(OF_CPU_PORT_MASK) << OF_ACTION_DATA_OUTPUT_PORT_POS;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_t;

  // Which source supplied a resolved action.
  typedef enum logic [1:0] {
    SRC_EXACT = 2'd0,
    SRC_WILD  = 2'd1,
    SRC_MISS  = 2'd2
  } act_src_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: the head entry is visible on dout_o whenever not empty.
module fallthrough_small_fifo #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             nearly_full_o,
  output logic             empty_o
);

  localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
  localparam int unsigned CNT_W = MAX_DEPTH_BITS + 1;

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      do_rd;
  logic                      do_wr;

  // A write into a full queue is accepted only when a pop frees a slot in the same cycle.
  assign do_rd = rd_en_i && (count_q != '0);
  assign do_wr = wr_en_i && ((count_q != CNT_W'(DEPTH)) || do_rd);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + MAX_DEPTH_BITS'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + MAX_DEPTH_BITS'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o        = mem_q[rd_ptr_q];
  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign nearly_full_o = (count_q >= CNT_W'(DEPTH - 1));

endmodule

// File: rtl/of_lookup_arbiter.sv
// Merges exact-match and wildcard lookup results into one prioritised action stream.
module of_lookup_arbiter
  import of_lookup_arbiter_pkg::*;
#(
  parameter int unsigned ACTION_DATA_WIDTH = OF_ACTION_DATA_WIDTH,
  parameter int unsigned ACTION_CTRL_WIDTH = OF_ACTION_CTRL_WIDTH,
  parameter int unsigned QUEUE_DEPTH_BITS  = 2,
  parameter int unsigned SYNC_TIMEOUT      = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         exact_valid,
  input  logic                         exact_hit,
  input  logic [ACTION_DATA_WIDTH-1:0] exact_action_data,
  input  logic [ACTION_CTRL_WIDTH-1:0] exact_action_ctrl,
  output logic                         exact_rdy,
  input  logic                         wild_valid,
  input  logic                         wild_hit,
  input  logic [ACTION_DATA_WIDTH-1:0] wild_action_data,
  input  logic [ACTION_CTRL_WIDTH-1:0] wild_action_ctrl,
  output logic                         wild_rdy,
  input  logic [ACTION_DATA_WIDTH-1:0] miss_action_data,
  input  logic [ACTION_CTRL_WIDTH-1:0] miss_action_ctrl,
  output logic [ACTION_DATA_WIDTH-1:0] action_data_bus,
  output logic [ACTION_CTRL_WIDTH-1:0] action_ctrl_bus,
  output logic                         action_valid,
  input  logic                         action_nearly_full,
  output logic [31:0]                  exact_hit_count,
  output logic [31:0]                  wild_hit_count,
  output logic [31:0]                  miss_count,
  output logic                         sync_error
);

  localparam int unsigned ENTRY_W = 1 + ACTION_CTRL_WIDTH + ACTION_DATA_WIDTH;
  localparam int unsigned TIMER_W = $clog2(SYNC_TIMEOUT + 1);

  arb_state_t state_q, state_d;

  logic [ENTRY_W-1:0] exact_dout, wild_dout;
  logic exact_empty, exact_full, exact_nf;
  logic wild_empty, wild_full, wild_nf;
  logic exact_wr, wild_wr, exact_pop, wild_pop;
  logic exact_ovf, wild_ovf;
  logic issue, flush_enter;

  logic                         exact_head_hit, wild_head_hit;
  logic [ACTION_DATA_WIDTH-1:0] res_data;
  logic [ACTION_CTRL_WIDTH-1:0] res_ctrl;
  act_src_t                     res_src;

  logic [TIMER_W-1:0]           timeout_q, timeout_d;
  logic [ACTION_DATA_WIDTH-1:0] act_data_q, act_data_d;
  logic [ACTION_CTRL_WIDTH-1:0] act_ctrl_q, act_ctrl_d;
  logic                         act_valid_q, act_valid_d;
  logic [31:0]                  exact_cnt_q, exact_cnt_d;
  logic [31:0]                  wild_cnt_q, wild_cnt_d;
  logic [31:0]                  miss_cnt_q, miss_cnt_d;
  logic                         sync_err_q, sync_err_d;

  // Engine writes are ignored while flushing; overflow is a write the queue cannot take.
  assign exact_wr  = exact_valid && (state_q != ST_FLUSH);
  assign wild_wr   = wild_valid  && (state_q != ST_FLUSH);
  assign exact_ovf = exact_wr && exact_full && !exact_pop;
  assign wild_ovf  = wild_wr  && wild_full  && !wild_pop;

  fallthrough_small_fifo #(
    .WIDTH          (ENTRY_W),
    .MAX_DEPTH_BITS (QUEUE_DEPTH_BITS)
  ) u_exact_q (
    .clk           (clk),
    .reset         (reset),
    .wr_en_i       (exact_wr),
    .din_i         ({exact_hit, exact_action_ctrl, exact_action_data}),
    .rd_en_i       (exact_pop),
    .dout_o        (exact_dout),
    .full_o        (exact_full),
    .nearly_full_o (exact_nf),
    .empty_o       (exact_empty)
  );

  fallthrough_small_fifo #(
    .WIDTH          (ENTRY_W),
    .MAX_DEPTH_BITS (QUEUE_DEPTH_BITS)
  ) u_wild_q (
    .clk           (clk),
    .reset         (reset),
    .wr_en_i       (wild_wr),
    .din_i         ({wild_hit, wild_action_ctrl, wild_action_data}),
    .rd_en_i       (wild_pop),
    .dout_o        (wild_dout),
    .full_o        (wild_full),
    .nearly_full_o (wild_nf),
    .empty_o       (wild_empty)
  );

  assign exact_head_hit = exact_dout[ENTRY_W-1];
  assign wild_head_hit  = wild_dout[ENTRY_W-1];

  // Priority resolution of the queue heads: exact hit, then wildcard hit, then miss.
  always_comb begin
    res_data = miss_action_data;
    res_ctrl = miss_action_ctrl;
    res_src  = SRC_MISS;
    if (exact_head_hit) begin
      res_data = exact_dout[ACTION_DATA_WIDTH-1:0];
      res_ctrl = exact_dout[ENTRY_W-2 -: ACTION_CTRL_WIDTH];
      res_src  = SRC_EXACT;
    end else if (wild_head_hit) begin
      res_data = wild_dout[ACTION_DATA_WIDTH-1:0];
      res_ctrl = wild_dout[ENTRY_W-2 -: ACTION_CTRL_WIDTH];
      res_src  = SRC_WILD;
    end
  end

  // Pairing watchdog: counts while exactly one queue holds results, saturating at the limit.
  always_comb begin
    timeout_d = timeout_q;
    if ((state_q == ST_FLUSH) || !(exact_empty ^ wild_empty)) begin
      timeout_d = '0;
    end else if (!action_nearly_full && (timeout_q != TIMER_W'(SYNC_TIMEOUT))) begin
      timeout_d = timeout_q + TIMER_W'(1);
    end
  end

  // FSM next-state and queue pop control.
  always_comb begin
    state_d     = state_q;
    exact_pop   = 1'b0;
    wild_pop    = 1'b0;
    issue       = 1'b0;
    flush_enter = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (timeout_d >= TIMER_W'(SYNC_TIMEOUT)) begin
          state_d     = ST_FLUSH;
          flush_enter = 1'b1;
        end else if (!exact_empty && !wild_empty && !action_nearly_full) begin
          exact_pop = 1'b1;
          wild_pop  = 1'b1;
          issue     = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_IDLE;
      ST_FLUSH: begin
        exact_pop = !exact_empty;
        wild_pop  = !wild_empty;
        if (exact_empty && wild_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Action register, statistics and sticky pairing error next-state.
  always_comb begin
    act_data_d  = act_data_q;
    act_ctrl_d  = act_ctrl_q;
    act_valid_d = issue;
    exact_cnt_d = exact_cnt_q;
    wild_cnt_d  = wild_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    sync_err_d  = sync_err_q || exact_ovf || wild_ovf || flush_enter;
    if (issue) begin
      act_data_d = res_data;
      act_ctrl_d = res_ctrl;
      case (res_src)
        SRC_EXACT: exact_cnt_d = exact_cnt_q + 32'd1;
        SRC_WILD:  wild_cnt_d  = wild_cnt_q + 32'd1;
        default:   miss_cnt_d  = miss_cnt_q + 32'd1;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timeout_q   <= '0;
      act_data_q  <= '0;
      act_ctrl_q  <= '0;
      act_valid_q <= 1'b0;
      exact_cnt_q <= '0;
      wild_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timeout_q   <= timeout_d;
      act_data_q  <= act_data_d;
      act_ctrl_q  <= act_ctrl_d;
      act_valid_q <= act_valid_d;
      exact_cnt_q <= exact_cnt_d;
      wild_cnt_q  <= wild_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // Ready is withheld during reset so engines never write into a queue being cleared.
  assign exact_rdy = !reset && !exact_nf && (state_q != ST_FLUSH);
  assign wild_rdy  = !reset && !wild_nf  && (state_q != ST_FLUSH);

  assign action_data_bus = act_data_q;
  assign action_ctrl_bus = act_ctrl_q;
  assign action_valid    = act_valid_q;
  assign exact_hit_count = exact_cnt_q;
  assign wild_hit_count  = wild_cnt_q;
  assign miss_count      = miss_cnt_q;
  assign sync_error      = sync_err_q;

endmodule

// File: tb/tb_of_lookup_arbiter.sv
// Directed bench for of_lookup_arbiter: priority, ordering, backpressure, timeout, reset.
module tb_of_lookup_arbiter;
  import of_lookup_arbiter_pkg::*;

  localparam int unsigned DW = OF_ACTION_DATA_WIDTH;
  localparam int unsigned CW = OF_ACTION_CTRL_WIDTH;
  localparam logic [DW-1:0] MISS_D = 64'h0000_0000_0000_0002;
  localparam logic [CW-1:0] MISS_C = 16'h0001;

  logic          clk = 1'b0;
  logic          reset;
  logic          exact_valid, exact_hit, wild_valid, wild_hit;
  logic [DW-1:0] exact_action_data, wild_action_data;
  logic [CW-1:0] exact_action_ctrl, wild_action_ctrl;
  logic          exact_rdy, wild_rdy;
  logic [DW-1:0] action_data_bus;
  logic [CW-1:0] action_ctrl_bus;
  logic          action_valid, action_nearly_full, sync_error;
  logic [31:0]   exact_hit_count, wild_hit_count, miss_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_ex = 0, exp_wi = 0, exp_mi = 0;
  logic [DW-1:0] got_d[$];
  logic [CW-1:0] got_c[$];
  int            got_cyc[$];

  of_lookup_arbiter #(
    .ACTION_DATA_WIDTH (DW),
    .ACTION_CTRL_WIDTH (CW),
    .QUEUE_DEPTH_BITS  (2),
    .SYNC_TIMEOUT      (16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .exact_valid        (exact_valid),
    .exact_hit          (exact_hit),
    .exact_action_data  (exact_action_data),
    .exact_action_ctrl  (exact_action_ctrl),
    .exact_rdy          (exact_rdy),
    .wild_valid         (wild_valid),
    .wild_hit           (wild_hit),
    .wild_action_data   (wild_action_data),
    .wild_action_ctrl   (wild_action_ctrl),
    .wild_rdy           (wild_rdy),
    .miss_action_data   (OF_MISS_ACTION_DATA),
    .miss_action_ctrl   (OF_MISS_ACTION_CTRL),
    .action_data_bus    (action_data_bus),
    .action_ctrl_bus    (action_ctrl_bus),
    .action_valid       (action_valid),
    .action_nearly_full (action_nearly_full),
    .exact_hit_count    (exact_hit_count),
    .wild_hit_count     (wild_hit_count),
    .miss_count         (miss_count),
    .sync_error         (sync_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every issued action with the cycle it was seen in.
  always @(negedge clk) begin
    if (action_valid === 1'b1) begin
      got_d.push_back(action_data_bus);
      got_c.push_back(action_ctrl_bus);
      got_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_d.delete();
    got_c.delete();
    got_cyc.delete();
  endtask

  task automatic idle_inputs();
    exact_valid = 1'b0;
    wild_valid  = 1'b0;
  endtask

  task automatic drive_exact(input logic hit, input logic [DW-1:0] d, input logic [CW-1:0] c);
    exact_valid = 1'b1; exact_hit = hit; exact_action_data = d; exact_action_ctrl = c;
  endtask

  task automatic drive_wild(input logic hit, input logic [DW-1:0] d, input logic [CW-1:0] c);
    wild_valid = 1'b1; wild_hit = hit; wild_action_data = d; wild_action_ctrl = c;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    exact_hit = 1'b0; wild_hit = 1'b0;
    exact_action_data = '0; wild_action_data = '0;
    exact_action_ctrl = '0; wild_action_ctrl = '0;
    action_nearly_full = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++; if (exact_rdy !== 1'b0) begin errors++; $display("FAIL reset_exact_rdy: got %b expected 0", exact_rdy); end
    checks++; if (wild_rdy !== 1'b0) begin errors++; $display("FAIL reset_wild_rdy: got %b expected 0", wild_rdy); end
    checks++; if (action_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", action_valid); end
    checks++; if (action_data_bus !== '0 || action_ctrl_bus !== '0) begin errors++; $display("FAIL reset_bus: got %h/%h expected 0/0", action_data_bus, action_ctrl_bus); end
    checks++; if (exact_hit_count !== 32'd0 || wild_hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", exact_hit_count, wild_hit_count, miss_count); end
    checks++; if (sync_error !== 1'b0) begin errors++; $display("FAIL reset_sync_error: got %b expected 0", sync_error); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (exact_rdy !== 1'b1 || wild_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_rdy: got %b%b expected 11", exact_rdy, wild_rdy); end
  endtask

  task automatic test_exact_priority();
    int c0;
    clear_log();
    tick();
    c0 = cyc;
    drive_exact(1'b1, 64'hA, 16'h0101);
    drive_wild(1'b1, 64'hB, 16'h0201);
    tick();
    idle_inputs();
    repeat (5) tick();
    exp_ex = exp_ex + 1;
    checks++; if (got_d.size() != 1) begin errors++; $display("FAIL single_count: got %0d actions expected 1", got_d.size()); end
    else begin
      checks++; if (got_cyc[0] != c0 + 2) begin errors++; $display("FAIL single_latency: got cycle %0d expected %0d", got_cyc[0], c0 + 2); end
      checks++; if (got_d[0] !== 64'hA || got_c[0] !== 16'h0101) begin errors++; $display("FAIL single_data: got %h/%h expected a/0101", got_d[0], got_c[0]); end
    end
    checks++; if (exact_hit_count !== 32'(exp_ex) || wild_hit_count !== 32'(exp_wi)) begin errors++; $display("FAIL single_counts: got %0d/%0d expected %0d/%0d", exact_hit_count, wild_hit_count, exp_ex, exp_wi); end
    checks++; if (action_data_bus !== 64'hA) begin errors++; $display("FAIL bus_hold: got %h expected a", action_data_bus); end
  endtask

  task automatic test_wild_and_miss();
    logic [DW-1:0] ed[2];
    logic [CW-1:0] ec[2];
    ed[0] = 64'hB;  ec[0] = 16'h0202;
    ed[1] = MISS_D; ec[1] = MISS_C;
    clear_log();
    drive_exact(1'b0, 64'hE1, 16'h0102);
    drive_wild(1'b1, 64'hB, 16'h0202);
    tick();
    drive_exact(1'b0, 64'hE2, 16'h0103);
    drive_wild(1'b0, 64'hE3, 16'h0203);
    tick();
    idle_inputs();
    repeat (6) tick();
    exp_wi = exp_wi + 1;
    exp_mi = exp_mi + 1;
    checks++; if (got_d.size() != 2) begin errors++; $display("FAIL wm_count: got %0d actions expected 2", got_d.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (got_d[i] !== ed[i] || got_c[i] !== ec[i]) begin errors++; $display("FAIL wm_action%0d: got %h/%h expected %h/%h", i, got_d[i], got_c[i], ed[i], ec[i]); end
      end
    end
    checks++; if (wild_hit_count !== 32'(exp_wi) || miss_count !== 32'(exp_mi) || exact_hit_count !== 32'(exp_ex)) begin errors++; $display("FAIL wm_counts: got %0d/%0d/%0d expected %0d/%0d/%0d", exact_hit_count, wild_hit_count, miss_count, exp_ex, exp_wi, exp_mi); end
  endtask

  task automatic test_backpressure();
    int  c0;
    bit  done;
    clear_log();
    action_nearly_full = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      drive_exact(1'b1, DW'(64'h11 + i), CW'(16'h0110 + i));
      drive_wild(1'b1, DW'(64'h21 + i), CW'(16'h0210 + i));
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (exact_rdy !== 1'b0 || wild_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_drop: got %b%b expected 00", exact_rdy, wild_rdy); end
    while (cyc < c0 + 10) tick();
    checks++; if (got_d.size() != 0) begin errors++; $display("FAIL bp_hold: got %0d actions expected 0", got_d.size()); end
    action_nearly_full = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (exact_rdy === 1'b1 && wild_rdy === 1'b1) begin
        drive_exact(1'b1, 64'h14, 16'h0113);
        drive_wild(1'b1, 64'h24, 16'h0213);
        done = 1'b1;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL bp_rdy_return: got rdy low expected rdy high after release"); end
    tick();
    idle_inputs();
    repeat (10) tick();
    exp_ex = exp_ex + 4;
    checks++; if (got_d.size() != 4) begin errors++; $display("FAIL bp_count: got %0d actions expected 4", got_d.size()); end
    else begin
      checks++; if (got_cyc[0] != c0 + 11) begin errors++; $display("FAIL bp_first_cycle: got %0d expected %0d", got_cyc[0], c0 + 11); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_d[i] !== DW'(64'h11 + i)) begin errors++; $display("FAIL bp_order%0d: got %h expected %h", i, got_d[i], 64'h11 + i); end
        if (i > 0) begin
          checks++; if (got_cyc[i] - got_cyc[i-1] != 2) begin errors++; $display("FAIL bp_spacing%0d: got %0d expected 2", i, got_cyc[i] - got_cyc[i-1]); end
        end
      end
    end
    checks++; if (exact_hit_count !== 32'(exp_ex)) begin errors++; $display("FAIL bp_exact_count: got %0d expected %0d", exact_hit_count, exp_ex); end
  endtask

  task automatic test_delayed_pairing();
    int c0;
    clear_log();
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      case (k)
        0: drive_exact(1'b0, 64'h31, 16'h0131);
        3: drive_exact(1'b1, 64'h32, 16'h0132);
        5: drive_wild(1'b1, 64'h41, 16'h0241);
        6: drive_wild(1'b0, 64'h42, 16'h0242);
        default: ;
      endcase
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    exp_wi = exp_wi + 1;
    exp_ex = exp_ex + 1;
    checks++; if (got_d.size() != 2) begin errors++; $display("FAIL dly_count: got %0d actions expected 2", got_d.size()); end
    else begin
      checks++; if (got_d[0] !== 64'h41 || got_cyc[0] != c0 + 7) begin errors++; $display("FAIL dly_first: got %h at %0d expected 41 at %0d", got_d[0], got_cyc[0], c0 + 7); end
      checks++; if (got_d[1] !== 64'h32 || got_cyc[1] != c0 + 9) begin errors++; $display("FAIL dly_second: got %h at %0d expected 32 at %0d", got_d[1], got_cyc[1], c0 + 9); end
    end
    checks++; if (sync_error !== 1'b0) begin errors++; $display("FAIL dly_sync_error: got %b expected 0", sync_error); end
    checks++; if (exact_hit_count !== 32'(exp_ex) || wild_hit_count !== 32'(exp_wi)) begin errors++; $display("FAIL dly_counts: got %0d/%0d expected %0d/%0d", exact_hit_count, wild_hit_count, exp_ex, exp_wi); end
  endtask

  task automatic test_timeout();
    int c0;
    int t_err = -1;
    int t_rdy = -1;
    clear_log();
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      drive_exact(1'b1, DW'(64'h91 + i), 16'h0190);
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sync_error === 1'b1) begin t_err = cyc; break; end
    end
    checks++; if (t_err != c0 + 17) begin errors++; $display("FAIL to_sync_error_cycle: got %0d expected %0d", t_err, c0 + 17); end
    checks++; if (exact_rdy !== 1'b0 || wild_rdy !== 1'b0) begin errors++; $display("FAIL to_flush_rdy: got %b%b expected 00", exact_rdy, wild_rdy); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (exact_rdy === 1'b1) begin t_rdy = cyc; break; end
    end
    checks++; if (t_rdy != c0 + 21) begin errors++; $display("FAIL to_flush_end: got %0d expected %0d", t_rdy, c0 + 21); end
    checks++; if (got_d.size() != 0) begin errors++; $display("FAIL to_no_action: got %0d actions expected 0", got_d.size()); end
    tick();
    drive_exact(1'b1, 64'h51, 16'h0151);
    drive_wild(1'b0, 64'h52, 16'h0252);
    tick();
    idle_inputs();
    repeat (5) tick();
    exp_ex = exp_ex + 1;
    checks++; if (got_d.size() != 1 || got_d[0] !== 64'h51) begin errors++; $display("FAIL to_recover: got %0d actions first %h expected 1 action 51", got_d.size(), got_d.size() > 0 ? got_d[0] : '0); end
    checks++; if (sync_error !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", sync_error); end
    checks++; if (exact_hit_count !== 32'(exp_ex)) begin errors++; $display("FAIL to_exact_count: got %0d expected %0d", exact_hit_count, exp_ex); end
  endtask

  task automatic test_reset_in_issue();
    clear_log();
    drive_exact(1'b1, 64'h77, 16'h0177);
    tick();
    drive_exact(1'b1, 64'h79, 16'h0179);
    drive_wild(1'b0, 64'h78, 16'h0278);
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    exp_ex = 0; exp_wi = 0; exp_mi = 0;
    checks++; if (got_d.size() != 0 || action_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid: got %0d actions valid %b expected 0 0", got_d.size(), action_valid); end
    checks++; if (exact_hit_count !== 32'd0 || wild_hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL rst_issue_counts: got %0d/%0d/%0d expected 0/0/0", exact_hit_count, wild_hit_count, miss_count); end
    checks++; if (sync_error !== 1'b0 || action_data_bus !== '0) begin errors++; $display("FAIL rst_issue_state: got err %b bus %h expected 0 0", sync_error, action_data_bus); end
    tick();
    drive_exact(1'b0, 64'h7A, 16'h017A);
    drive_wild(1'b1, 64'h7B, 16'h027B);
    tick();
    idle_inputs();
    repeat (6) tick();
    exp_wi = 1;
    checks++; if (got_d.size() != 1 || got_d[0] !== 64'h7B) begin errors++; $display("FAIL rst_queues_empty: got %0d actions first %h expected 1 action 7b", got_d.size(), got_d.size() > 0 ? got_d[0] : '0); end
    checks++; if (wild_hit_count !== 32'(exp_wi) || exact_hit_count !== 32'(exp_ex)) begin errors++; $display("FAIL rst_after_counts: got %0d/%0d expected %0d/%0d", exact_hit_count, wild_hit_count, exp_ex, exp_wi); end
  endtask

  task automatic test_overflow();
    action_nearly_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_exact(1'b1, DW'(64'hC0 + i), 16'h01C0);
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (sync_error !== 1'b0) begin errors++; $display("FAIL ovf_full_ok: got %b expected 0", sync_error); end
    tick();
    drive_exact(1'b1, 64'hC4, 16'h01C4);
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (sync_error !== 1'b1) begin errors++; $display("FAIL ovf_sync_error: got %b expected 1", sync_error); end
    action_nearly_full = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_exact_priority();
    test_wild_and_miss();
    test_backpressure();
    test_delayed_pairing();
    test_timeout();
    test_reset_in_issue();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
